// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU sweep sequencer: FSM states,
// sweep dimensions and the fixed operand pair table.
package alu_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int NUM_OPS   = 16;
    localparam int NUM_PAIRS = 5;
    localparam int OUT_W     = 20;
    localparam int NUM_VECS  = NUM_OPS * NUM_PAIRS;

    // Entry [0] is the first pair swept for every opcode.
    localparam logic [NUM_PAIRS-1:0][3:0] PAIR_A = {4'hB, 4'hC, 4'h3, 4'h2, 4'h1};
    localparam logic [NUM_PAIRS-1:0][3:0] PAIR_B = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

    // Returns {a, b} for a pair index; out-of-range indices map to zero.
    function automatic logic [7:0] pair_ab(input logic [2:0] idx);
        case (idx)
            3'd0:    pair_ab = {PAIR_A[0], PAIR_B[0]};
            3'd1:    pair_ab = {PAIR_A[1], PAIR_B[1]};
            3'd2:    pair_ab = {PAIR_A[2], PAIR_B[2]};
            3'd3:    pair_ab = {PAIR_A[3], PAIR_B[3]};
            3'd4:    pair_ab = {PAIR_A[4], PAIR_B[4]};
            default: pair_ab = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/alu_sweep_vec_ctr.sv
// Nested opcode/pair counter: pair is the inner loop, opcode the outer loop.
// Exposes the next position so the caller can register operands early.
module alu_sweep_vec_ctr
    import alu_sweep_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [3:0] sel_nxt_o,
    output logic [2:0] pair_nxt_o,
    output logic       last_o
);

    logic [3:0] sel_q, sel_d;
    logic [2:0] pair_q, pair_d;
    logic       wrap;

    assign wrap = (pair_q == 3'(NUM_PAIRS - 1));

    always_comb begin
        sel_nxt_o  = wrap ? sel_q + 4'd1 : sel_q;
        pair_nxt_o = wrap ? 3'd0 : pair_q + 3'd1;
        last_o     = wrap && (sel_q == 4'(NUM_OPS - 1));
        sel_d      = sel_q;
        pair_d     = pair_q;
        if (clear_i) begin
            sel_d  = 4'd0;
            pair_d = 3'd0;
        end else if (advance_i) begin
            sel_d  = sel_nxt_o;
            pair_d = pair_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= 4'd0;
            pair_q <= 3'd0;
        end else begin
            sel_q  <= sel_d;
            pair_q <= pair_d;
        end
    end

endmodule

// File: rtl/alu_sweep_seq.sv
// Sweeps 16 opcodes x 5 operand pairs through an external combinational ALU,
// streaming each captured {sel,a,b,y} word over a valid/ready interface.
module alu_sweep_seq
    import alu_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [6:0]       vec_cnt,
    output logic [15:0]      checksum
);

    state_e state_q, state_d;

    logic [3:0]       settle_q, settle_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [6:0]       vec_cnt_q, vec_cnt_d;
    logic [15:0]      checksum_q, checksum_d;

    logic       start_sweep, handshake, settled;
    logic [3:0] sel_nxt;
    logic [2:0] pair_nxt;
    logic       last;
    logic [7:0] ab_first, ab_nxt;

    assign start_sweep = (state_q == ST_IDLE) && start;
    assign handshake   = (state_q == ST_EMIT) && out_ready;
    assign settled     = (settle_q == 4'(SETTLE_CYCLES - 1));
    assign ab_first    = pair_ab(3'd0);
    assign ab_nxt      = pair_ab(pair_nxt);

    alu_sweep_vec_ctr u_vec_ctr (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (start_sweep),
        .advance_i  (handshake && !last),
        .sel_nxt_o  (sel_nxt),
        .pair_nxt_o (pair_nxt),
        .last_o     (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  if (settled) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_EMIT;
            ST_EMIT:   if (out_ready) state_d = last ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        out_valid = (state_q == ST_EMIT);
    end

    // Operands only change at a sweep start or an EMIT handshake, so they
    // stay stable from the first DRIVE cycle through EMIT of each vector.
    always_comb begin
        settle_d   = (state_q == ST_DRIVE) ? settle_q + 4'd1 : 4'd0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        out_data_d = out_data_q;
        vec_cnt_d  = vec_cnt_q;
        checksum_d = checksum_q;
        if (start_sweep) begin
            vec_cnt_d  = 7'd0;
            checksum_d = 16'd0;
            alu_sel_d  = 4'd0;
            {alu_a_d, alu_b_d} = ab_first;
        end
        if (state_q == ST_SAMPLE) begin
            out_data_d = {alu_sel_q, alu_a_q, alu_b_q, alu_y};
            checksum_d = checksum_q + {8'd0, alu_y};
        end
        if (handshake) begin
            vec_cnt_d = vec_cnt_q + 7'd1;
            if (!last) begin
                alu_sel_d = sel_nxt;
                {alu_a_d, alu_b_d} = ab_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q   <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_sel_q  <= 4'd0;
            out_data_q <= '0;
            vec_cnt_q  <= 7'd0;
            checksum_q <= 16'd0;
        end else begin
            settle_q   <= settle_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            out_data_q <= out_data_d;
            vec_cnt_q  <= vec_cnt_d;
            checksum_q <= checksum_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign out_data = out_data_q;
    assign vec_cnt  = vec_cnt_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Bench for alu_sweep_seq: two instances (settle 1 and 3) driven by a
// reference ALU, checked against a sweep model and hand-computed words.
module tb_alu_sweep_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start1 = 1'b0, ready1 = 1'b0;
    logic        busy1, done1, ov1;
    logic [3:0]  a1, b1, sel1;
    logic [7:0]  y1;
    logic [19:0] od1;
    logic [6:0]  vc1;
    logic [15:0] cs1;

    logic        start3 = 1'b0, ready3 = 1'b0;
    logic        busy3, done3, ov3;
    logic [3:0]  a3, b3, sel3;
    logic [7:0]  y3;
    logic [19:0] od3;
    logic [6:0]  vc3;
    logic [15:0] cs3;

    function automatic logic [7:0] alu_ref(input logic [3:0] s, input logic [3:0] a,
                                           input logic [3:0] b);
        case (s)
            4'd0:    return {4'd0, a} + {4'd0, b};
            4'd1:    return {4'd0, a} - {4'd0, b};
            4'd2:    return {4'd0, a & b};
            4'd3:    return {4'd0, a | b};
            4'd4:    return {4'd0, a ^ b};
            4'd5:    return {4'd0, a} * {4'd0, b};
            default: return {s, a} ^ {b, 4'h0};
        endcase
    endfunction

    assign y1 = alu_ref(sel1, a1, b1);
    assign y3 = alu_ref(sel3, a3, b3);

    alu_sweep_seq #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_y(y1),
        .out_valid(ov1), .out_ready(ready1), .out_data(od1),
        .vec_cnt(vc1), .checksum(cs1)
    );

    alu_sweep_seq #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .alu_a(a3), .alu_b(b3), .alu_sel(sel3), .alu_y(y3),
        .out_valid(ov3), .out_ready(ready3), .out_data(od3),
        .vec_cnt(vc3), .checksum(cs3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          idx;
        logic [19:0] word;
    } vec_t;
    vec_t tbl[6];

    logic [3:0]  pa[5];
    logic [3:0]  pb[5];
    logic [19:0] exp_q[$];
    logic [15:0] exp_sum;
    logic [19:0] got1[$];
    logic [19:0] got3[$];

    int          d1c, d3c, d1n, d3n;
    logic [19:0] hold_data;
    logic [11:0] hold_ops;
    bit          seen;

    initial begin
        // Hand-computed words: index = sel*5 + pair.
        tbl[0] = '{0,  20'h01506};
        tbl[1] = '{1,  20'h02406};
        tbl[2] = '{5,  20'h115FC};
        tbl[3] = '{13, 20'h2C200};
        tbl[4] = '{27, 20'h53309};
        tbl[5] = '{79, 20'hFB1EB};

        pa = '{4'd1, 4'd2, 4'd3, 4'hC, 4'hB};
        pb = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        exp_sum = 16'd0;
        for (int s = 0; s < 16; s++)
            for (int p = 0; p < 5; p++) begin
                exp_q.push_back({4'(s), pa[p], pb[p], alu_ref(4'(s), pa[p], pb[p])});
                exp_sum = exp_sum + 16'(alu_ref(4'(s), pa[p], pb[p]));
            end

        // Reset state
        repeat (3) step();
        check("reset_outputs_s1", {busy1, done1, ov1, od1, a1, b1, sel1, vc1, cs1}, 64'd0);
        check("reset_outputs_s3", {busy3, done3, ov3, od3, a3, b3, sel3, vc3, cs3}, 64'd0);
        rst = 1'b0;
        step();

        // Full sweeps on both instances; stray starts on dut1 while busy.
        d1c = -1; d3c = -1; d1n = 0; d3n = 0;
        ready1 = 1'b1; ready3 = 1'b1;
        start1 = 1'b1; start3 = 1'b1;
        step();
        start1 = 1'b0; start3 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (ov1 && ready1) got1.push_back(od1);
            if (ov3 && ready3) got3.push_back(od3);
            if (done1) begin if (d1c < 0) d1c = n; d1n++; end
            if (done3) begin if (d3c < 0) d3c = n; d3n++; end
            start1 = busy1 && !done1 && ($urandom_range(0, 7) == 0);
            step();
        end
        start1 = 1'b0;
        // done visible after edge n is sampled by edge n+1 (241 / 401).
        check("done_time_s1", 64'(d1c + 1), 64'd241);
        check("done_time_s3", 64'(d3c + 1), 64'd401);
        check("done_width_s1", 64'(d1n), 64'd1);
        check("done_width_s3", 64'(d3n), 64'd1);
        check("vec_cnt_s1", 64'(vc1), 64'd80);
        check("vec_cnt_s3", 64'(vc3), 64'd80);
        check("checksum_s1", 64'(cs1), 64'(exp_sum));
        check("checksum_s3", 64'(cs3), 64'(exp_sum));
        check("idle_busy_s1", 64'(busy1), 64'd0);
        check("words_s1", 64'(got1.size()), 64'd80);
        check("words_s3", 64'(got3.size()), 64'd80);
        for (int i = 0; i < 80 && i < got1.size(); i++) check($sformatf("word_s1_%0d", i), 64'(got1[i]), 64'(exp_q[i]));
        for (int i = 0; i < 80 && i < got3.size(); i++) check($sformatf("word_s3_%0d", i), 64'(got3[i]), 64'(exp_q[i]));
        foreach (tbl[k])
            if (tbl[k].idx < got1.size()) check($sformatf("table_%0d", tbl[k].idx), 64'(got1[tbl[k].idx]), 64'(tbl[k].word));
            else check($sformatf("table_%0d_missing", tbl[k].idx), 64'(got1.size()), 64'(tbl[k].idx + 1));

        // Backpressure on first EMIT, then random ready for the rest.
        got1.delete();
        ready1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 20 && !ov1; k++) step();
        check("bp_first_valid", 64'(ov1), 64'd1);
        hold_data = od1;
        hold_ops  = {sel1, a1, b1};
        check("bp_first_word", 64'(hold_data), 64'h01506);
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_valid_held", 64'(ov1), 64'd1);
            check("bp_data_held", 64'(od1), 64'(hold_data));
            check("bp_ops_held", 64'({sel1, a1, b1}), 64'(hold_ops));
        end
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            ready1 = 1'($urandom_range(0, 1));
            if (ov1 && ready1) got1.push_back(od1);
            start1 = busy1 && !done1 && ($urandom_range(0, 5) == 0);
            step();
            seen = done1;
        end
        start1 = 1'b0;
        check("rand_done_seen", 64'(seen), 64'd1);
        check("rand_words", 64'(got1.size()), 64'd80);
        for (int i = 0; i < 80 && i < got1.size(); i++) check($sformatf("rand_word_%0d", i), 64'(got1[i]), 64'(exp_q[i]));
        check("rand_checksum", 64'(cs1), 64'(exp_sum));
        step();

        // Reset during EMIT of vector 37, then rst-over-start, then restart.
        ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 500 && !(ov1 && vc1 == 7'd36); k++) step();
        check("mid_emit_reached", 64'({ov1, vc1}), 64'({1'b1, 7'd36}));
        rst = 1'b1;
        step();
        check("mid_rst_outputs", {busy1, done1, ov1, od1, a1, b1, sel1, vc1, cs1}, 64'd0);
        start1 = 1'b1;
        step();
        check("rst_over_start", 64'(busy1), 64'd0);
        rst = 1'b0;
        step();
        start1 = 1'b0;
        check("restart_busy", 64'(busy1), 64'd1);
        check("restart_ops", 64'({sel1, a1, b1}), 64'h015);
        for (int k = 0; k < 20 && !ov1; k++) step();
        check("restart_first_word", 64'(od1), 64'h01506);
        check("restart_vec_cnt", 64'(vc1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
